divide_ratio_detector: RTL and testbench

Measures the rising-edge period of a divided clock derived from `clk_in` and classifies it as divide-by-2, 4, 8 or 16. It is the receiving end of the team's ripple divide-by counter and checks, in-system, which tap (f2/f4/f8/f16) is actually being delivered. A lock state machine asserts `locked` after several consecutive identical periods. It flags mismatches and loss of input.

---
 rtl/divide_ratio_detector.sv | 185 ++++++++++++++++++
 tb/tb_divide_ratio_detector.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/divide_ratio_detector.sv
// divide_ratio_detector: measures the rise-to-rise period of a divided clock
// sampled on clk_in, classifies it as /2, /4, /8 or /16, and locks after
// LOCK_COUNT consecutive identical classifications. Pulses mismatch when a
// lock is broken by a different period and timeout when the input goes quiet.
module divide_ratio_detector #(
  parameter int PW         = 8,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          sig_in,
  output logic [PW-1:0] period,
  output logic          period_valid,
  output logic [2:0]    ratio,
  output logic          locked,
  output logic          mismatch,
  output logic          timeout
);

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    CONFIRM = 2'd1,
    LOCKED  = 2'd2
  } state_t;

  localparam logic [PW-1:0] CNT_MAX = PW'(TIMEOUT - 1);
  localparam logic [3:0]    LOCK_N  = 4'(LOCK_COUNT);
  localparam logic [PW-1:0] P2      = PW'(2);
  localparam logic [PW-1:0] P4      = PW'(4);
  localparam logic [PW-1:0] P8      = PW'(8);
  localparam logic [PW-1:0] P16     = PW'(16);

  logic          sig_q;
  logic          sig_qq;
  logic          rise;
  logic          armed;
  logic [PW-1:0] cnt;
  logic [PW-1:0] cnt_inc;
  logic          measure;
  logic          fire_timeout;
  logic [2:0]    code;
  state_t        state;
  state_t        state_nxt;
  logic [2:0]    cand;
  logic [2:0]    cand_nxt;
  logic [3:0]    mcnt;
  logic [3:0]    mcnt_nxt;
  logic          mismatch_nxt;

  assign rise         = sig_q & ~sig_qq;
  assign cnt_inc      = cnt + 1'b1;
  assign measure      = rise & armed;
  assign fire_timeout = armed & ~rise & (cnt == CNT_MAX);

  // Two-flop sampling of the divided clock so a rising edge is seen as a one-cycle strobe
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sig_q  <= 1'b0;
      sig_qq <= 1'b0;
    end else begin
      sig_q  <= sig_in;
      sig_qq <= sig_q;
    end
  end

  // Cycles since the last rise; saturates so cnt+1 always fits in PW bits
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (rise) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt_inc;
    end
  end

  // First rise after reset or timeout only arms; a timeout disarms until the next rise
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (fire_timeout) begin
      armed <= 1'b0;
    end else if (rise) begin
      armed <= 1'b1;
    end
  end

  // Map the measured period onto a ratio code; anything but 2/4/8/16 is code 0
  always_comb begin
    code = 3'd0;
    if (cnt_inc == P2) begin
      code = 3'd1;
    end else if (cnt_inc == P4) begin
      code = 3'd2;
    end else if (cnt_inc == P8) begin
      code = 3'd3;
    end else if (cnt_inc == P16) begin
      code = 3'd4;
    end
  end

  // Lock FSM next state: timeout overrides everything, otherwise act on each measurement
  always_comb begin
    state_nxt    = state;
    cand_nxt     = cand;
    mcnt_nxt     = mcnt;
    mismatch_nxt = 1'b0;
    if (fire_timeout) begin
      state_nxt = SEARCH;
      cand_nxt  = 3'd0;
      mcnt_nxt  = 4'd0;
    end else if (measure) begin
      case (state)
        SEARCH: begin
          if (code != 3'd0) begin
            cand_nxt  = code;
            mcnt_nxt  = 4'd1;
            state_nxt = (LOCK_N == 4'd1) ? LOCKED : CONFIRM;
          end
        end
        CONFIRM: begin
          if (code == 3'd0) begin
            state_nxt = SEARCH;
            mcnt_nxt  = 4'd0;
          end else if (code == cand) begin
            mcnt_nxt = mcnt + 4'd1;
            if (mcnt + 4'd1 == LOCK_N) begin
              state_nxt = LOCKED;
            end
          end else begin
            cand_nxt = code;
            mcnt_nxt = 4'd1;
          end
        end
        LOCKED: begin
          if (code != cand) begin
            mismatch_nxt = 1'b1;
            state_nxt    = SEARCH;
            mcnt_nxt     = 4'd0;
          end
        end
        default: begin
          state_nxt = SEARCH;
          mcnt_nxt  = 4'd0;
        end
      endcase
    end
  end

  // Lock FSM state, candidate and match counter registers
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= SEARCH;
      cand  <= 3'd0;
      mcnt  <= 4'd0;
    end else begin
      state <= state_nxt;
      cand  <= cand_nxt;
      mcnt  <= mcnt_nxt;
    end
  end

  // Registered outputs, updated on the same edge as the FSM so they stay aligned
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      period       <= '0;
      period_valid <= 1'b0;
      ratio        <= 3'd0;
      locked       <= 1'b0;
      mismatch     <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= measure;
      if (measure) begin
        period <= cnt_inc;
      end
      locked   <= (state_nxt == LOCKED);
      ratio    <= (state_nxt == LOCKED) ? cand_nxt : 3'd0;
      mismatch <= mismatch_nxt;
      timeout  <= fire_timeout;
    end
  end

endmodule

// File: tb/tb_divide_ratio_detector.sv
// tb_divide_ratio_detector: drives divided-clock patterns into two detectors
// (LOCK_COUNT 4 and 1) and compares every cycle against a timestamp-based
// reference model, plus table-driven and hand-written corner sequences.
module tb_divide_ratio_detector;

  localparam int PW      = 8;
  localparam int TIMEOUT = 64;

  logic          clk_in = 1'b0;
  logic          rst_n  = 1'b0;
  logic          sig_in = 1'b0;

  logic [PW-1:0] period0, period1;
  logic          pv0, pv1;
  logic [2:0]    ratio0, ratio1;
  logic          locked0, locked1;
  logic          mis0, mis1;
  logic          to0, to1;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Reference model: works from rise timestamps rather than counters
  int   cur_time    = 0;
  logic prev_sample = 1'b0;
  logic pending     = 1'b0;
  int   lock_need [2] = '{4, 1};
  logic m_armed  [2];
  int   m_last_t [2];
  logic m_locked [2];
  int   m_cand   [2];
  int   m_streak [2];
  int   m_period [2];
  logic m_pv     [2];
  logic m_mis    [2];
  logic m_to     [2];

  // Event counters observed from the DUTs for the corner sequences
  int pv_seen  [2];
  int lock_at  [2];
  int mis_seen [2];
  int to_seen  [2];

  typedef struct {
    int hi;
    int lo;
    int reps;
    int exp_period;
    int exp_ratio;
    int exp_locked;
  } vec_t;

  vec_t vecs [7];

  divide_ratio_detector #(.PW(PW), .LOCK_COUNT(4), .TIMEOUT(TIMEOUT)) dut0 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
    .period(period0), .period_valid(pv0), .ratio(ratio0),
    .locked(locked0), .mismatch(mis0), .timeout(to0)
  );

  divide_ratio_detector #(.PW(PW), .LOCK_COUNT(1), .TIMEOUT(TIMEOUT)) dut1 (
    .clk_in(clk_in), .rst_n(rst_n), .sig_in(sig_in),
    .period(period1), .period_valid(pv1), .ratio(ratio1),
    .locked(locked1), .mismatch(mis1), .timeout(to1)
  );

  always #5 clk_in = ~clk_in;

  function automatic int classify(input int p);
    if (p >= 2 && p <= 16 && ((p & (p - 1)) == 0)) return $clog2(p);
    return 0;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_compared++;
    if (act != exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s at t=%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    prev_sample = 1'b0;
    pending     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_armed[i]  = 1'b0;
      m_last_t[i] = 0;
      m_locked[i] = 1'b0;
      m_cand[i]   = 0;
      m_streak[i] = 0;
      m_period[i] = 0;
      m_pv[i]     = 1'b0;
      m_mis[i]    = 1'b0;
      m_to[i]     = 1'b0;
    end
  endtask

  task automatic model_code(input int i, input int c);
    if (m_locked[i]) begin
      if (c != m_cand[i]) begin
        m_mis[i]    = 1'b1;
        m_locked[i] = 1'b0;
        m_streak[i] = 0;
      end
    end else if (c == 0) begin
      m_streak[i] = 0;
    end else begin
      if (m_streak[i] > 0 && c == m_cand[i]) begin
        m_streak[i]++;
      end else begin
        m_cand[i]   = c;
        m_streak[i] = 1;
      end
      if (m_streak[i] >= lock_need[i]) m_locked[i] = 1'b1;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        m_pv[i]  = 1'b0;
        m_mis[i] = 1'b0;
        m_to[i]  = 1'b0;
        if (pending) begin
          if (m_armed[i]) begin
            m_period[i] = cur_time - m_last_t[i];
            m_pv[i]     = 1'b1;
            model_code(i, classify(m_period[i]));
          end
          m_armed[i]  = 1'b1;
          m_last_t[i] = cur_time;
        end else if (m_armed[i] && (cur_time - m_last_t[i] == TIMEOUT)) begin
          m_to[i]     = 1'b1;
          m_armed[i]  = 1'b0;
          m_locked[i] = 1'b0;
          m_streak[i] = 0;
          m_cand[i]   = 0;
        end
      end
      pending     = sig_in & ~prev_sample;
      prev_sample = sig_in;
    end
    cur_time++;
  endtask

  task automatic compare_inst(input int i, input int p, input int pv, input int r,
                              input int l, input int mi, input int t);
    string tag;
    tag = (i == 0) ? "lc4" : "lc1";
    checkOutput({tag, " period"},       p,  m_period[i]);
    checkOutput({tag, " period_valid"}, pv, int'(m_pv[i]));
    checkOutput({tag, " ratio"},        r,  m_locked[i] ? m_cand[i] : 0);
    checkOutput({tag, " locked"},       l,  int'(m_locked[i]));
    checkOutput({tag, " mismatch"},     mi, int'(m_mis[i]));
    checkOutput({tag, " timeout"},      t,  int'(m_to[i]));
  endtask

  // One clock: drive at the falling edge, sample 1 time unit after the rising edge
  task automatic applyStimulus(input logic v);
    @(negedge clk_in);
    sig_in = v;
    @(posedge clk_in);
    #1;
    model_edge();
    compare_inst(0, int'(period0), int'(pv0), int'(ratio0), int'(locked0), int'(mis0), int'(to0));
    compare_inst(1, int'(period1), int'(pv1), int'(ratio1), int'(locked1), int'(mis1), int'(to1));
    if (pv0) pv_seen[0]++;
    if (pv1) pv_seen[1]++;
    if (locked0 && lock_at[0] < 0) lock_at[0] = pv_seen[0];
    if (locked1 && lock_at[1] < 0) lock_at[1] = pv_seen[1];
    if (mis0) mis_seen[0]++;
    if (mis1) mis_seen[1]++;
    if (to0) to_seen[0]++;
    if (to1) to_seen[1]++;
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    model_reset();
    applyStimulus(1'b0);
    applyStimulus(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      pv_seen[i]  = 0;
      lock_at[i]  = -1;
      mis_seen[i] = 0;
      to_seen[i]  = 0;
    end
  endtask

  task automatic run_pattern(input int hi, input int lo, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < hi; k++) applyStimulus(1'b1);
      for (int k = 0; k < lo; k++) applyStimulus(1'b0);
    end
  endtask

  initial begin
    vecs[0] = '{hi: 1, lo: 1, reps: 8, exp_period: 2,  exp_ratio: 1, exp_locked: 1};
    vecs[1] = '{hi: 2, lo: 2, reps: 8, exp_period: 4,  exp_ratio: 2, exp_locked: 1};
    vecs[2] = '{hi: 4, lo: 4, reps: 8, exp_period: 8,  exp_ratio: 3, exp_locked: 1};
    vecs[3] = '{hi: 8, lo: 8, reps: 8, exp_period: 16, exp_ratio: 4, exp_locked: 1};
    vecs[4] = '{hi: 3, lo: 3, reps: 8, exp_period: 6,  exp_ratio: 0, exp_locked: 0};
    vecs[5] = '{hi: 1, lo: 7, reps: 8, exp_period: 8,  exp_ratio: 3, exp_locked: 1};
    vecs[6] = '{hi: 2, lo: 3, reps: 8, exp_period: 5,  exp_ratio: 0, exp_locked: 0};

    reset_dut();
    checkOutput("reset period", int'(period0), 0);
    checkOutput("reset locked", int'(locked0), 0);

    // Table-driven steady patterns
    for (int v = 0; v < 7; v++) begin
      reset_dut();
      run_pattern(vecs[v].hi, vecs[v].lo, vecs[v].reps);
      checkOutput($sformatf("vec%0d period", v), int'(period0), vecs[v].exp_period);
      checkOutput($sformatf("vec%0d ratio", v),  int'(ratio0),  vecs[v].exp_ratio);
      checkOutput($sformatf("vec%0d locked", v), int'(locked0), vecs[v].exp_locked);
      checkOutput($sformatf("vec%0d lc1 ratio", v),  int'(ratio1),  vecs[v].exp_ratio);
      checkOutput($sformatf("vec%0d lc1 locked", v), int'(locked1), vecs[v].exp_locked);
    end

    // Lock point: LOCK_COUNT 4 locks on 4th measurement, LOCK_COUNT 1 on the first
    reset_dut();
    run_pattern(8, 8, 6);
    checkOutput("f16 lock_at lc4", lock_at[0], 4);
    checkOutput("f16 lock_at lc1", lock_at[1], 1);

    // Locked on /4, switch to /8: one mismatch then relock on /8
    reset_dut();
    run_pattern(2, 2, 8);
    checkOutput("div4 locked", int'(locked0), 1);
    run_pattern(4, 4, 8);
    checkOutput("switch mismatch count lc4", mis_seen[0], 1);
    checkOutput("switch mismatch count lc1", mis_seen[1], 1);
    checkOutput("switch relock ratio", int'(ratio0), 3);

    // Locked on /8 then input stops: single timeout, then arm + relock
    reset_dut();
    run_pattern(4, 4, 8);
    for (int k = 0; k < 100; k++) applyStimulus(1'b0);
    checkOutput("idle timeout count lc4", to_seen[0], 1);
    checkOutput("idle timeout count lc1", to_seen[1], 1);
    checkOutput("idle locked", int'(locked0), 0);
    checkOutput("idle ratio", int'(ratio0), 0);
    run_pattern(4, 4, 6);
    checkOutput("resume locked", int'(locked0), 1);

    // Asynchronous reset mid-lock clears outputs before the next clock edge
    reset_dut();
    run_pattern(2, 2, 8);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async period", int'(period0), 0);
    checkOutput("async locked", int'(locked0), 0);
    checkOutput("async ratio", int'(ratio0), 0);
    checkOutput("async pv", int'(pv0), 0);
    checkOutput("async lc1 locked", int'(locked1), 0);
    model_reset();
    applyStimulus(1'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) lock_at[i] = -1;
    for (int i = 0; i < 2; i++) pv_seen[i] = 0;
    run_pattern(2, 2, 6);
    checkOutput("post-reset lock_at", lock_at[0], 4);

    // Randomised periods, duty cycles and idle gaps against the model
    reset_dut();
    for (int r = 0; r < 40; r++) begin
      int p;
      int sel;
      sel = $urandom_range(0, 5);
      case (sel)
        0: p = 2;
        1: p = 4;
        2: p = 8;
        3: p = 16;
        default: p = $urandom_range(2, 20);
      endcase
      run_pattern($urandom_range(1, p - 1), 0, 0);
      begin
        int hi;
        hi = $urandom_range(1, p - 1);
        run_pattern(hi, p - hi, $urandom_range(1, 7));
      end
      if ($urandom_range(0, 7) == 0) begin
        int gap;
        gap = $urandom_range(50, 90);
        for (int k = 0; k < gap; k++) applyStimulus(1'b0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
